// File: rtl/shadow_restore_controller.sv
// shadow_restore_controller
// Return path of the shadow-register mechanism. On an mret from a nested
// trap level it reads the saved frame back through a single read port,
// refills x1 and x3..xNUM_REGS, hands mepc/mcause to the CSR file,
// rebuilds sp as base + frame size and pops one nesting level.
//
// Frame layout (B = DATA_WIDTH/8 bytes per slot):
//   slot 0 = mepc, slot 1 = mcause, slot k+1 = xk (k = 1..NUM_REGS).
//   Slot 3 holds x2 and is never read; sp is recomputed instead.
//
// Handshakes:
//   restore_req_i is a one-cycle pulse accepted only while restore_ready_o=1.
//   mem_req_o/mem_addr_o stay stable until the cycle mem_gnt_i is high;
//   mem_rvalid_i for that request arrives strictly after the gnt cycle and
//   at most one request is outstanding. rvalid seen in IDLE or REQ is stale
//   and dropped.
//
// Optional feature: define SHADOW_RESTORE_ABORT_EN to add abort_i, which
// cancels a restore in REQ or RESP (pending rvalid is drained, no level pop).
//
// dbg_state_o exposes the FSM state encoding for checkers.

module shadow_restore_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 15,
  parameter int LEVEL_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   restore_req_i,
  input  logic [DATA_WIDTH-1:0]  restore_sp_i,
  output logic                   restore_ready_o,
  input  logic [LEVEL_WIDTH-1:0] save_level_i,
  output logic                   level_dec_o,
  output logic                   restore_err_o,
  output logic                   stall_o,
  output logic                   mem_req_o,
  output logic [DATA_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [DATA_WIDTH-1:0]  rf_wdata_o,
  output logic                   csr_restore_valid_o,
  output logic [DATA_WIDTH-1:0]  mepc_o,
  output logic [DATA_WIDTH-1:0]  mcause_o,
`ifdef SHADOW_RESTORE_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic [2:0]             dbg_state_o
);

  localparam logic [DATA_WIDTH-1:0] SLOT_BYTES  = DATA_WIDTH'(DATA_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] FRAME_BYTES = DATA_WIDTH'((NUM_REGS + 2) * (DATA_WIDTH / 8));
  localparam logic [5:0]            LAST_SLOT   = 6'(NUM_REGS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_SP_WB = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [5:0]              slot_q, slot_d;
  logic [DATA_WIDTH-1:0]   base_q, base_d;
  logic                    drain_q, drain_d;
  logic                    err_q, err_d;
  logic                    rf_we_q, rf_we_d;
  logic [4:0]              rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic [DATA_WIDTH-1:0]   mepc_q, mepc_d;
  logic [DATA_WIDTH-1:0]   mcause_q, mcause_d;
  logic                    abort_w;

`ifdef SHADOW_RESTORE_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // State and datapath registers; reset leaves partial regfile writes alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      base_q     <= '0;
      drain_q    <= 1'b0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      base_q     <= base_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  // Next-state logic: sequence slots 0,1,2,4..LAST_SLOT, then sp write-back.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    base_d     = base_q;
    drain_d    = drain_q;
    err_d      = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    case (state_q)
      S_IDLE: begin
        drain_d = 1'b0;
        if (restore_req_i) begin
          if (save_level_i != '0) begin
            base_d  = restore_sp_i;
            slot_d  = '0;
            state_d = S_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (abort_w)        state_d = S_IDLE;
        else if (mem_gnt_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (abort_w) drain_d = 1'b1;
        if (mem_rvalid_i) begin
          if (abort_w || drain_q) begin
            // Cancelled: swallow the outstanding response and stop.
            drain_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            if (slot_q == 6'd0) begin
              mepc_d = mem_rdata_i;
            end else if (slot_q == 6'd1) begin
              mcause_d = mem_rdata_i;
            end else begin
              rf_we_d    = 1'b1;
              rf_waddr_d = 5'(slot_q - 6'd1);
              rf_wdata_d = mem_rdata_i;
            end
            if (slot_q == LAST_SLOT) begin
              state_d = S_SP_WB;
            end else begin
              slot_d  = (slot_q == 6'd2) ? 6'd4 : slot_q + 6'd1;
              state_d = S_REQ;
            end
          end
        end
      end
      S_SP_WB: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = 5'd2;
        rf_wdata_d = base_q + FRAME_BYTES;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: status from state, writes and CSR values from registers.
  always_comb begin
    restore_ready_o     = (state_q == S_IDLE);
    stall_o             = (state_q != S_IDLE);
    mem_req_o           = (state_q == S_REQ);
    mem_addr_o          = (state_q == S_REQ) ? base_q + (DATA_WIDTH'(slot_q) * SLOT_BYTES) : '0;
    level_dec_o         = (state_q == S_DONE);
    csr_restore_valid_o = (state_q == S_DONE);
    restore_err_o       = err_q;
    rf_we_o             = rf_we_q;
    rf_waddr_o          = rf_waddr_q;
    rf_wdata_o          = rf_wdata_q;
    mepc_o              = mepc_q;
    mcause_o            = mcause_q;
    dbg_state_o         = state_q;
  end

endmodule

// File: tb/tb_shadow_restore_controller.sv
// tb_shadow_restore_controller
// Directed bench for shadow_restore_controller: nominal restore, zero level
// error, gnt back-pressure, address wrap, reset mid-restore and (with
// SHADOW_RESTORE_ABORT_EN) abort in RESP. Memory returns 0xA0 + slot.

module tb_shadow_restore_controller;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        restore_req_i;
  logic [31:0] restore_sp_i;
  logic        restore_ready_o;
  logic [4:0]  save_level_i;
  logic        level_dec_o;
  logic        restore_err_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        csr_restore_valid_o;
  logic [31:0] mepc_o;
  logic [31:0] mcause_o;
  logic [2:0]  dbg_state_o;
`ifdef SHADOW_RESTORE_ABORT_EN
  logic        abort_i;
`endif

  always #5 clk = ~clk;

  shadow_restore_controller dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .restore_req_i       (restore_req_i),
    .restore_sp_i        (restore_sp_i),
    .restore_ready_o     (restore_ready_o),
    .save_level_i        (save_level_i),
    .level_dec_o         (level_dec_o),
    .restore_err_o       (restore_err_o),
    .stall_o             (stall_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_gnt_i           (mem_gnt_i),
    .mem_rvalid_i        (mem_rvalid_i),
    .mem_rdata_i         (mem_rdata_i),
    .rf_we_o             (rf_we_o),
    .rf_waddr_o          (rf_waddr_o),
    .rf_wdata_o          (rf_wdata_o),
    .csr_restore_valid_o (csr_restore_valid_o),
    .mepc_o              (mepc_o),
    .mcause_o            (mcause_o),
`ifdef SHADOW_RESTORE_ABORT_EN
    .abort_i             (abort_i),
`endif
    .dbg_state_o         (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  logic [36:0] exp_q[$];          // {waddr, wdata} expected regfile writes
  logic [31:0] first_addr[$];     // address of each request, first REQ cycle
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_dec    = 0;
  int n_csr    = 0;
  int n_err    = 0;
  int n_extra  = 0;
  int req_cnt  = 0;
  int stall_slot = -1;
  int gnt_slot = 0;
  logic [31:0] cur_base = '0;
  logic [31:0] cap_mepc, cap_mcause;
  logic        cap_csr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, score writes, drive memory inputs.
  task automatic tick();
    logic g_old;
    int   slot;
    @(negedge clk);
    cyc++;
    if (rf_we_o) begin
      if (exp_q.size() == 0) n_extra++;
      else check("rf_write", {27'b0, rf_waddr_o, rf_wdata_o}, {27'b0, exp_q.pop_front()});
    end
    if (level_dec_o) begin
      n_dec++;
      cap_mepc   = mepc_o;
      cap_mcause = mcause_o;
      cap_csr    = csr_restore_valid_o;
    end
    if (csr_restore_valid_o) n_csr++;
    if (restore_err_o) n_err++;
    // Memory: rvalid the cycle after gnt; gnt after a per-slot wait.
    g_old        = mem_gnt_i;
    mem_rvalid_i = g_old;
    mem_rdata_i  = 32'hA0 + 32'(gnt_slot);
    mem_gnt_i    = 1'b0;
    if (mem_req_o) begin
      slot = int'((mem_addr_o - cur_base) >> 2);
      req_cnt++;
      if (req_cnt == 1) first_addr.push_back(mem_addr_o);
      if (slot == stall_slot && req_cnt >= 2 && req_cnt <= 7) begin
        check("stall_req", mem_req_o, 1);
        check("stall_addr", mem_addr_o, cur_base + 32'h10);
        check("stall_no_wr", rf_we_o, 0);
      end
      if (req_cnt > ((slot == stall_slot) ? 7 : 1)) begin
        mem_gnt_i = 1'b1;
        gnt_slot  = slot;
        req_cnt   = 0;
      end
    end else begin
      req_cnt = 0;
    end
  endtask

  // Expected writes for a full frame with memory word 0xA0+slot.
  task automatic push_frame(input logic [31:0] base);
    exp_q.push_back({5'd1, 32'hA2});
    for (int k = 3; k <= 15; k++) exp_q.push_back({5'(k), 32'hA0 + 32'(k + 1)});
    exp_q.push_back({5'd2, base + 32'h44});
  endtask

  // Issue one request and run until level_dec_o (bounded); returns latency.
  task automatic run_restore(input logic [31:0] base, input bit poke, output int lat);
    int start, dec0;
    dec0 = n_dec;
    cur_base = base;
    first_addr.delete();
    restore_sp_i  = base;
    restore_req_i = 1'b1;
    start = cyc;
    tick();
    restore_req_i = 1'b0;
    restore_sp_i  = '0;
    lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      if (poke && cyc - start == 10) begin
        restore_req_i = 1'b1;
        save_level_i  = 5'd0;
        restore_sp_i  = 32'hDEAD_0000;
      end else if (poke && cyc - start == 11) begin
        restore_req_i = 1'b0;
        save_level_i  = 5'd2;
      end
      tick();
      if (n_dec != dec0) lat = cyc - start;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, dec0, err0;
    rst_i = 1'b1;
    restore_req_i = 1'b0;
    restore_sp_i  = '0;
    save_level_i  = 5'd2;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
`ifdef SHADOW_RESTORE_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) tick();

    // Reset values
    check("rst_ready", restore_ready_o, 1);
    check("rst_stall", stall_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_rf_we", rf_we_o, 0);
    check("rst_level_dec", level_dec_o, 0);
    check("rst_csr_valid", csr_restore_valid_o, 0);
    check("rst_err", restore_err_o, 0);
    check("rst_mepc", mepc_o, 0);
    check("rst_state", dbg_state_o, 0);
    rst_i = 1'b0;
    tick();

    // Nominal restore, with an ignored request poked mid-flight
    push_frame(32'h8000_0F00);
    run_restore(32'h8000_0F00, 1'b1, lat);
    check("nom_latency", 32'(lat), 50);
    check("nom_mepc", cap_mepc, 32'hA0);
    check("nom_mcause", cap_mcause, 32'hA1);
    check("nom_csr_with_dec", cap_csr, 1);
    check("nom_dec_count", 32'(n_dec), 1);
    check("nom_csr_count", 32'(n_csr), 1);
    check("nom_no_err_busy", 32'(n_err), 0);
    check("nom_writes_left", 32'(exp_q.size()), 0);
    check("nom_req_count", 32'(first_addr.size()), 16);
    check("nom_addr_slot0", first_addr[0], 32'h8000_0F00);
    check("nom_addr_skip3", first_addr[3], 32'h8000_0F10);
    check("nom_addr_last", first_addr[15], 32'h8000_0F40);
    tick();
    check("nom_ready_after", restore_ready_o, 1);
    check("nom_dec_pulse", level_dec_o, 0);

    // Zero nesting level: error pulse, nothing else
    save_level_i  = 5'd0;
    restore_sp_i  = 32'h1234_0000;
    restore_req_i = 1'b1;
    tick();
    restore_req_i = 1'b0;
    save_level_i  = 5'd2;
    check("zero_err_pulse", restore_err_o, 1);
    check("zero_ready", restore_ready_o, 1);
    check("zero_mem_req", mem_req_o, 0);
    tick();
    check("zero_err_once", restore_err_o, 0);
    check("zero_mem_req2", mem_req_o, 0);
    check("zero_err_count", 32'(n_err), 1);

    // Back-pressure on slot 4: gnt low 7 cycles (+6 cycles latency)
    stall_slot = 4;
    push_frame(32'h0000_1000);
    run_restore(32'h0000_1000, 1'b0, lat);
    stall_slot = -1;
    check("bp_latency", 32'(lat), 56);
    check("bp_writes_left", 32'(exp_q.size()), 0);
    tick();

    // Reset mid-restore at slot 6 with its rvalid due next cycle
    dec0 = n_dec;
    cur_base = 32'h0000_3000;
    first_addr.delete();
    exp_q.push_back({5'd1, 32'hA2});
    exp_q.push_back({5'd3, 32'hA4});
    exp_q.push_back({5'd4, 32'hA5});
    restore_sp_i  = 32'h0000_3000;
    restore_req_i = 1'b1;
    tick();
    restore_req_i = 1'b0;
    for (int i = 0; i < 100 && !(mem_gnt_i && gnt_slot == 6); i++) tick();
    check("rr_reached_slot6", {mem_gnt_i, 31'(gnt_slot)}, {1'b1, 31'd6});
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rr_ready", restore_ready_o, 1);
    check("rr_rf_we", rf_we_o, 0);
    check("rr_level_dec", level_dec_o, 0);
    check("rr_stall", stall_o, 0);
    tick();  // stale rvalid lands in IDLE
    check("rr_stale_ready", restore_ready_o, 1);
    check("rr_stale_rf_we", rf_we_o, 0);
    check("rr_stale_mem_req", mem_req_o, 0);
    check("rr_no_dec", 32'(n_dec - dec0), 0);
    check("rr_partial_writes", 32'(exp_q.size()), 0);

    // Address wrap; also shows the restart begins at slot 0
    push_frame(32'hFFFF_FFF8);
    run_restore(32'hFFFF_FFF8, 1'b0, lat);
    check("wrap_latency", 32'(lat), 50);
    check("wrap_addr_slot0", first_addr[0], 32'hFFFF_FFF8);
    check("wrap_addr_slot2", first_addr[2], 32'h0000_0000);
    check("wrap_writes_left", 32'(exp_q.size()), 0);
    tick();

`ifdef SHADOW_RESTORE_ABORT_EN
    // Abort in RESP of slot 5: its rvalid is discarded
    dec0 = n_dec;
    err0 = n_csr;
    cur_base = 32'h0000_2000;
    exp_q.push_back({5'd1, 32'hA2});
    exp_q.push_back({5'd3, 32'hA4});
    restore_sp_i  = 32'h0000_2000;
    restore_req_i = 1'b1;
    tick();
    restore_req_i = 1'b0;
    for (int i = 0; i < 100 && !(mem_gnt_i && gnt_slot == 5); i++) tick();
    check("ab_reached_slot5", {mem_gnt_i, 31'(gnt_slot)}, {1'b1, 31'd5});
    tick();  // DUT in RESP, rvalid now driven
    check("ab_in_resp", dbg_state_o, 3'd2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("ab_ready", restore_ready_o, 1);
    check("ab_no_write", rf_we_o, 0);
    repeat (5) tick();
    check("ab_no_dec", 32'(n_dec - dec0), 0);
    check("ab_no_csr", 32'(n_csr - err0), 0);
    check("ab_writes_left", 32'(exp_q.size()), 0);
`else
    err0 = 0;
`endif

    check("extra_writes", 32'(n_extra), 0);
    check("final_ready", restore_ready_o, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
